// File: rtl/canny_frame_ctrl.sv
// -----------------------------------------------------------------------------
// canny_frame_ctrl
//   Frame sequencer for the Canny edge pipeline. A start pulse fetches one
//   IMG_W x IMG_H frame of 8-bit pixels from a pixel memory and streams it into
//   the datapath. Returned edge pixels are tagged with row/column and
//   end-of-line/end-of-frame flags. A watchdog in FLUSH traps a stalled
//   datapath.
//
//   Optional build macro: CANNY_EDGE_COUNT_EN enables the o_edge_cnt counter
//   (count of tagged outputs with a non-zero edge value, saturating). Without
//   it o_edge_cnt is tied to zero.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle frame start (honoured in IDLE / ERR only)
//   src_ready         memory can accept a read this cycle
//   src_rd, src_addr  read strobe and linear row-major address
//   src_data          read data, valid the cycle after src_rd
//   pix_out/pix_valid pixel stream to the datapath
//   dp_edge/dp_out_valid  edge stream back from the datapath
//   o_edge/o_valid    registered edge pixel
//   o_col/o_row       position of o_edge
//   o_eol/o_eof       last column / last pixel of frame
//   busy              high in FEED and FLUSH
//   done              one-cycle frame completion pulse (with o_eof)
//   err_timeout       sticky flush-timeout flag
//   o_edge_cnt        non-zero edge count (feature build only, else 0)
// -----------------------------------------------------------------------------
module canny_frame_ctrl #(
  parameter int unsigned IMG_W         = 3124,
  parameter int unsigned IMG_H         = 3030,
  parameter int unsigned ADDR_W        = 24,
  parameter int unsigned FLUSH_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              src_ready,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic [7:0]        pix_out,
  output logic              pix_valid,
  input  logic [7:0]        dp_edge,
  input  logic              dp_out_valid,
  output logic [7:0]        o_edge,
  output logic              o_valid,
  output logic [15:0]       o_col,
  output logic [15:0]       o_row,
  output logic              o_eol,
  output logic              o_eof,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [23:0]       o_edge_cnt
);

  localparam int unsigned       NPIX      = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [15:0]       COL_LAST  = 16'(IMG_W - 1);
  localparam logic [15:0]       ROW_LAST  = 16'(IMG_H - 1);
  localparam int unsigned       WD_W      = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(FLUSH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [15:0]       col_q, col_d;
  logic [15:0]       row_q, row_d;
  logic              full_q, full_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic              pv_q;
  logic [7:0]        o_edge_q;
  logic              o_valid_q;
  logic [15:0]       o_col_q, o_row_q;
  logic              o_eol_q, o_eof_q;
  logic              busy_q, done_q;

  logic rd;      // read issued this cycle
  logic emit;    // datapath output accepted for tagging
  logic last;    // accepted output is the final pixel of the frame
  logic clr;     // frame (re)start: clear counters

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    col_d    = col_q;
    row_d    = row_q;
    full_d   = full_q;
    wd_d     = wd_q;
    err_d    = err_q;
    rd       = 1'b0;
    clr      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          clr     = 1'b1;
        end
      end
      S_FEED: begin
        if (src_ready) begin
          rd       = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST_ADDR) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (dp_out_valid) begin
          wd_d = '0;
        end else begin
          wd_d = wd_q + 1'b1;
          if (wd_q == WD_LAST) state_d = S_ERR;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        if (start) begin
          state_d = S_FEED;
          clr     = 1'b1;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Tagging runs in FEED and FLUSH; outputs past the frame end are dropped
    // and the position counters stay parked on the last pixel.
    emit = dp_out_valid && !full_q && (state_q == S_FEED || state_q == S_FLUSH);
    last = emit && (col_q == COL_LAST) && (row_q == ROW_LAST);
    if (emit) begin
      if (last) begin
        full_d = 1'b1;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 16'd1;
      end else begin
        col_d = col_q + 16'd1;
      end
    end

    // Completion overrides a coincident watchdog expiry.
    if (state_q == S_FLUSH && (last || full_q)) state_d = S_DONE;
    if (state_q == S_FLUSH && state_d == S_ERR) err_d = 1'b1;

    if (clr) begin
      rd_cnt_d = '0;
      col_d    = '0;
      row_d    = '0;
      full_d   = 1'b0;
      wd_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_cnt_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      full_q    <= 1'b0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      pv_q      <= 1'b0;
      o_edge_q  <= '0;
      o_valid_q <= 1'b0;
      o_col_q   <= '0;
      o_row_q   <= '0;
      o_eol_q   <= 1'b0;
      o_eof_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      full_q    <= full_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
      pv_q      <= rd;
      o_valid_q <= emit;
      o_eol_q   <= emit && (col_q == COL_LAST);
      o_eof_q   <= last;
      if (emit) begin
        o_edge_q <= dp_edge;
        o_col_q  <= col_q;
        o_row_q  <= row_q;
      end
      busy_q <= (state_d == S_FEED) || (state_d == S_FLUSH);
      done_q <= (state_d == S_DONE);
    end
  end

`ifdef CANNY_EDGE_COUNT_EN
  logic [23:0] ecnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ecnt_q <= '0;
    end else if (clr) begin
      ecnt_q <= '0;
    end else if (emit && (dp_edge != '0) && (ecnt_q != '1)) begin
      ecnt_q <= ecnt_q + 24'd1;
    end
  end

  assign o_edge_cnt = ecnt_q;
`else
  assign o_edge_cnt = '0;
`endif

  assign src_rd      = rd;
  assign src_addr    = rd ? rd_cnt_q : '0;
  assign pix_valid   = pv_q;
  // The memory registers its read data, so it is already stable for the whole
  // cycle after src_rd; it is gated onto the stream alongside pix_valid.
  assign pix_out     = pv_q ? src_data : '0;
  assign o_edge      = o_edge_q;
  assign o_valid     = o_valid_q;
  assign o_col       = o_col_q;
  assign o_row       = o_row_q;
  assign o_eol       = o_eol_q;
  assign o_eof       = o_eof_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
`timescale 1ns/1ps
module tb_canny_frame_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned N  = W * H;
  localparam int unsigned AW = 8;
  localparam int unsigned FT = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          src_ready;
  logic          src_rd;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_data = '0;
  logic [7:0]    pix_out;
  logic          pix_valid;
  logic [7:0]    dp_edge;
  logic          dp_out_valid;
  logic [7:0]    o_edge;
  logic          o_valid;
  logic [15:0]   o_col;
  logic [15:0]   o_row;
  logic          o_eol;
  logic          o_eof;
  logic          busy;
  logic          done;
  logic          err_timeout;
  logic [23:0]   o_edge_cnt;

  always #5 clk = ~clk;

  canny_frame_ctrl #(
    .IMG_W        (W),
    .IMG_H        (H),
    .ADDR_W       (AW),
    .FLUSH_TIMEOUT(FT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .src_ready   (src_ready),
    .src_rd      (src_rd),
    .src_addr    (src_addr),
    .src_data    (src_data),
    .pix_out     (pix_out),
    .pix_valid   (pix_valid),
    .dp_edge     (dp_edge),
    .dp_out_valid(dp_out_valid),
    .o_edge      (o_edge),
    .o_valid     (o_valid),
    .o_col       (o_col),
    .o_row       (o_row),
    .o_eol       (o_eol),
    .o_eof       (o_eof),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .o_edge_cnt  (o_edge_cnt)
  );

  // ---------------- environment: pixel memory and datapath ----------------
  logic [7:0] mem [N];
  bit         em;          // datapath transfer mode
  bit         drop_tail;   // datapath swallows its last two results
  logic       dp_clr;
  logic       spur_valid;
  logic [4:0] pv;
  logic [39:0] pd;
  int unsigned dp_cnt;

  function automatic logic [7:0] edge_of(input logic [7:0] p, input bit m);
    return m ? (p[0] ? 8'hFF : 8'h00) : ~p;
  endfunction

  always @(posedge clk) begin
    if (src_rd) src_data <= mem[src_addr];
  end

  // Fixed 5-cycle datapath latency.
  always @(posedge clk) begin
    if (!rst_n || dp_clr) begin
      pv     <= '0;
      pd     <= '0;
      dp_cnt <= 0;
    end else begin
      pv <= {pv[3:0], pix_valid && !(drop_tail && dp_cnt >= N - 2)};
      pd <= {pd[31:0], edge_of(pix_out, em)};
      if (pix_valid) dp_cnt <= dp_cnt + 1;
    end
  end

  assign dp_out_valid = pv[4] | spur_valid;
  assign dp_edge      = spur_valid ? 8'h77 : pd[39:32];

  // ---------------- checking ----------------
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model state ----------------
  bit          active;     // frame in FEED/FLUSH
  bit          prev_rd;
  bit          err_m;
  bit          pend_err;
  int unsigned exp_addr, pix_idx, out_idx, n_out, quiet, ecnt;

  function automatic logic [31:0] exp_cnt();
`ifdef CANNY_EDGE_COUNT_EN
    return ecnt;
`else
    return 0;
`endif
  endfunction

  task automatic monitor();
    bit fl, exp_rd, done_exp;
    done_exp = 1'b0;
    if (pend_err) begin
      pend_err = 1'b0;
      active   = 1'b0;
      err_m    = 1'b1;
    end
    fl     = active && (exp_addr == N);
    exp_rd = active && src_ready && (exp_addr < N);
    check("src_rd", 32'(src_rd), 32'(exp_rd));
    if (exp_rd && src_rd) begin
      check("src_addr", 32'(src_addr), exp_addr);
      exp_addr++;
    end
    check("pix_valid", 32'(pix_valid), 32'(prev_rd));
    if (pix_valid && prev_rd && pix_idx < N) begin
      check("pix_out", 32'(pix_out), 32'(mem[pix_idx]));
      pix_idx++;
    end
    prev_rd = exp_rd;
    if (!active) begin
      check("o_valid_idle", 32'(o_valid), 0);
    end else if (o_valid) begin
      if (out_idx >= n_out) begin
        check("o_valid_extra", 32'(o_valid), 0);
      end else begin
        check("o_edge", 32'(o_edge), 32'(edge_of(mem[out_idx], em)));
        check("o_col", 32'(o_col), out_idx % W);
        check("o_row", 32'(o_row), out_idx / W);
        check("o_eol", 32'(o_eol), 32'((out_idx % W) == W - 1));
        check("o_eof", 32'(o_eof), 32'(out_idx == N - 1));
        if (edge_of(mem[out_idx], em) != 8'h00) ecnt++;
        out_idx++;
        if (out_idx == N) begin
          done_exp = 1'b1;
          active   = 1'b0;
        end
      end
    end
    check("done", 32'(done), 32'(done_exp));
    check("busy", 32'(busy), 32'(active));
    check("err_timeout", 32'(err_timeout), 32'(err_m));
    check("o_edge_cnt", 32'(o_edge_cnt), exp_cnt());
    if (fl && active) begin
      if (dp_out_valid) quiet = 0;
      else begin
        quiet++;
        if (quiet == FT) pend_err = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int unsigned i = 0; i < N; i++) mem[i] = 8'($urandom);
  endtask

  task automatic begin_frame(input bit drop);
    drop_tail = drop;
    n_out     = drop ? N - 2 : N;
    start     = 1'b1;
    dp_clr    = 1'b1;
    src_ready = 1'($urandom_range(0, 1));
    cyc();
    start    = 1'b0;
    dp_clr   = 1'b0;
    exp_addr = 0;
    pix_idx  = 0;
    out_idx  = 0;
    prev_rd  = 1'b0;
    quiet    = 0;
    ecnt     = 0;
    err_m    = 1'b0;
    pend_err = 1'b0;
    active   = 1'b1;
  endtask

  // rmode: 0 ready always, 1 alternating, 2 random
  task automatic run_frame(input int unsigned rmode, input bit drop, input bit mid_start);
    int unsigned budget;
    begin_frame(drop);
    budget = 0;
    while (active && budget < 300) begin
      case (rmode)
        0:       src_ready = 1'b1;
        1:       src_ready = (budget % 2) == 0;
        default: src_ready = 1'($urandom_range(0, 1));
      endcase
      start = mid_start && (budget == 4);
      cyc();
      budget++;
    end
    start = 1'b0;
    check("frame_terminated", 32'(active), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned k, picked;
    rst_n      = 1'b0;
    start      = 1'b0;
    src_ready  = 1'b1;
    dp_clr     = 1'b0;
    spur_valid = 1'b0;
    em         = 1'b0;
    drop_tail  = 1'b0;
    active     = 1'b0;
    prev_rd    = 1'b0;
    err_m      = 1'b0;
    pend_err   = 1'b0;
    exp_addr = 0; pix_idx = 0; out_idx = 0; n_out = N; quiet = 0; ecnt = 0;
    fill_mem();
    repeat (2) @(posedge clk);
    #1;
    check("rst_src_rd", 32'(src_rd), 0);
    check("rst_src_addr", 32'(src_addr), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_out", 32'(pix_out), 0);
    check("rst_o_valid", 32'(o_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_edge_cnt", 32'(o_edge_cnt), 0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // basic frame, then stalled source, then random ready with an ignored start
    run_frame(0, 1'b0, 1'b0);
    repeat (3) cyc();
    fill_mem();
    run_frame(1, 1'b0, 1'b0);
    repeat (2) cyc();

    // spurious datapath valid while idle must not tag or move counters
    spur_valid = 1'b1;
    repeat (2) cyc();
    spur_valid = 1'b0;
    repeat (2) cyc();
    fill_mem();
    run_frame(2, 1'b0, 1'b1);
    repeat (2) cyc();

    // datapath loses its last two results -> watchdog
    fill_mem();
    run_frame(0, 1'b1, 1'b0);
    check("timeout_flag", 32'(err_timeout), 1);
    repeat (4) cyc();
    fill_mem();
    run_frame(2, 1'b0, 1'b0);
    check("err_cleared", 32'(err_timeout), 0);
    repeat (2) cyc();

    // five non-zero edge results
    em = 1'b1;
    for (int unsigned i = 0; i < N; i++) mem[i] = 8'($urandom) & 8'hFE;
    picked = 0;
    while (picked < 5) begin
      k = $urandom_range(0, N - 1);
      if (!mem[k][0]) begin
        mem[k][0] = 1'b1;
        picked++;
      end
    end
    run_frame(0, 1'b0, 1'b0);
    repeat (3) cyc();
`ifdef CANNY_EDGE_COUNT_EN
    check("edge_cnt_held", 32'(o_edge_cnt), 5);
`else
    check("edge_cnt_held", 32'(o_edge_cnt), 0);
`endif
    begin_frame(1'b0);
    check("edge_cnt_cleared", 32'(o_edge_cnt), 0);

    // reset while feeding address 6
    k = 0;
    while (exp_addr < 6 && k < 50) begin
      src_ready = 1'b1;
      cyc();
      k++;
    end
    src_ready = 1'b1;
    rst_n = 1'b0;
    cyc();
    active   = 1'b0;
    prev_rd  = 1'b0;
    pend_err = 1'b0;
    err_m    = 1'b0;
    ecnt     = 0;
    check("mid_rst_pix_valid", 32'(pix_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_src_rd", 32'(src_rd), 0);
    check("mid_rst_src_addr", 32'(src_addr), 0);
    check("mid_rst_o_valid", 32'(o_valid), 0);
    check("mid_rst_o_col", 32'(o_col), 0);
    check("mid_rst_o_row", 32'(o_row), 0);
    check("mid_rst_o_edge", 32'(o_edge), 0);
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    em = 1'b0;
    fill_mem();
    run_frame(0, 1'b0, 1'b0);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/canny_frame_ctrl.md
Name: canny_frame_ctrl

Overview:
- Frame sequencer for the Canny edge pipeline (canny_top).
- On a start pulse it fetches one IMG_W x IMG_H frame of 8-bit pixels from a pixel memory and streams them into the datapath, one per clock, with a valid strobe.
- It then tags each returned edge pixel with its row and column plus end-of-line and end-of-frame flags, and reports when the frame is done.
- A flush watchdog catches a stalled datapath.

Parameters:
- IMG_W, 3124, frame width in pixels.
- IMG_H, 3030, frame height in pixels.
- ADDR_W, 24, pixel memory address width. Must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- FLUSH_TIMEOUT, 65535, maximum idle cycles in FLUSH with no dp_out_valid before declaring an error.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse that begins a frame. Honoured only in IDLE or ERR.
- src_ready  in  1  pixel memory may accept a read this cycle.
- src_rd  out  1  read strobe.
- src_addr  out  ADDR_W  read address (linear, row-major).
- src_data  in  8  read data, valid exactly 1 cycle after src_rd.
- pix_out  out  8  pixel to datapath pixel_in.
- pix_valid  out  1  to datapath in_valid.
- dp_edge  in  8  datapath edge_out.
- dp_out_valid  in  1  datapath out_valid.
- o_edge  out  8  registered edge pixel.
- o_valid  out  1  o_edge valid.
- o_col  out  16  column of o_edge.
- o_row  out  16  row of o_edge.
- o_eol  out  1  o_edge is column IMG_W-1.
- o_eof  out  1  o_edge is the last pixel of the frame.
- busy  out  1  high in FEED and FLUSH.
- done  out  1  one-cycle pulse at frame completion.
- err_timeout  out  1  sticky flush-timeout flag.

Behaviour:
- **Reset.** While rst_n=0 at a clk edge:
  - state=IDLE.
  - All outputs 0: src_rd, src_addr, pix_out, pix_valid, o_*, busy, done, err_timeout.
  - Read and output counters cleared.
  - An in-flight frame is abandoned. pix_valid is 0 from the first edge with rst_n=0.
- **States:** IDLE, FEED, FLUSH, DONE, ERR.
- **IDLE:** start=1 -> FEED; read address and output counters cleared. Other inputs ignored.
- **FEED:**
  - Each cycle with src_ready=1: src_rd=1, src_addr=rd_cnt, rd_cnt+1.
  - With src_ready=0: src_rd=0 and no increment.
  - The cycle after any src_rd=1: pix_valid=1 and pix_out=src_data (registered); otherwise pix_valid=0.
  - Issuing address IMG_W*IMG_H-1 -> FLUSH. The final pix_valid occurs in the first FLUSH cycle.
- **Output tagging (FEED and FLUSH):**
  - On dp_out_valid=1, the next cycle presents o_valid=1, o_edge=dp_edge, and o_col/o_row from the output counters.
  - o_eol=(o_col==IMG_W-1). o_eof=(last pixel).
  - o_col wraps IMG_W-1 -> 0 with o_row+1.
  - Outputs beyond IMG_W*IMG_H are dropped: no o_valid, counters saturate.
  - dp_out_valid in IDLE, DONE or ERR is ignored.
- **FLUSH:**
  - Watchdog counter cleared on every dp_out_valid; otherwise it increments.
  - The edge that registers the final output (o_eof) -> DONE.
  - Watchdog reaching FLUSH_TIMEOUT -> ERR.
  - If both occur on the same edge, DONE wins.
- **DONE:** done=1 for exactly one cycle, coincident with o_eof=1. Next state is IDLE.
- **ERR:** err_timeout=1 and busy=0. start clears err_timeout, clears counters and goes to FEED. Otherwise ERR holds.
- **Other rules:**
  - start outside IDLE/ERR is ignored, including start held high.
  - busy is a registered decode of state.

Optional Feature:
- Macro: CANNY_EDGE_COUNT_EN.
- When defined:
  - Adds output o_edge_cnt (24 bits): count of tagged outputs with dp_edge != 0.
  - Cleared on start; held stable from the done pulse until the next start.
  - Saturates at 2^24-1.
- When undefined: port o_edge_cnt is present but tied to 0, and no counter logic exists.

Test Plan:
- Benches use IMG_W=4, IMG_H=3 and a model datapath with fixed 5-cycle latency.
- **Basic frame.** src_ready=1 throughout, start pulse -> src_addr 0..11 on consecutive cycles; pix_valid 12 consecutive cycles, 1 cycle behind; 12 o_valid with o_eol at o_col=3 for rows 0..2; o_eof and done together on pixel 11; busy falls the next cycle.
- **Source stalls.** src_ready toggles 1,0,1,0... -> src_rd only on ready cycles, addresses still 0..11 without gaps or repeats; frame completes with 12 outputs.
- **Ignored start and spurious valid.** start reasserted mid-FEED and dp_out_valid pulsed in IDLE -> no restart, no o_valid, counters unchanged.
- **Flush timeout.** Datapath drops its last 2 outputs, FLUSH_TIMEOUT=16 -> err_timeout=1 after 16 idle FLUSH cycles, no done. A following start clears the error and a full frame completes.
- **Reset mid-operation.** rst_n=0 during FEED at address 6 -> next edge pix_valid=0, busy=0, all outputs 0. A restart after release begins at src_addr 0.
- **Edge count (CANNY_EDGE_COUNT_EN).** Model outputs 255 on 5 pixels, 0 elsewhere -> o_edge_cnt=5 at done, held until the next start.
